tag_rx_decoder: RTL and testbench

//  Receive-side decoder for the tag's 1 us/symbol DBPSK backscatter frame. Takes hard-decision

---
 rtl/tag_rx_decoder_pkg.sv | 26 ++
 rtl/tag_rx_decoder_crc32.sv | 42 ++++
 rtl/tag_rx_decoder.sv | 186 ++++++++++++++++++
 tb/tb_tag_rx_decoder.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tag_rx_decoder_pkg.sv
// Shared definitions for the DBPSK tag receive path: FSM state codes, CRC-32 constants
// and the single-bit CRC update used by both the decoder and the tag FCS generator.
package tag_rx_decoder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REF     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_FCS     = 3'd3,
        ST_HOLD    = 3'd4
    } state_t;

    localparam logic [31:0] CRC32_POLY    = 32'h04C1_1DB7;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
    localparam int          CYCLES_PER_US = 50;

    // Non-reflected serial CRC step: feedback is the outgoing MSB XOR the new bit.
    function automatic logic [31:0] crc32_step(input logic [31:0] crc,
                                               input logic        bit_in,
                                               input logic [31:0] poly);
        logic fb;
        fb = crc[31] ^ bit_in;
        crc32_step = {crc[30:0], 1'b0} ^ (fb ? poly : 32'h0000_0000);
    endfunction

endpackage

// File: rtl/tag_rx_decoder_crc32.sv
// Serial CRC-32 register: init has priority over enable; reusable by the tag FCS generator.
module crc32_serial
    import tag_rx_decoder_pkg::*;
#(
    parameter logic [31:0] POLY = CRC32_POLY,
    parameter logic [31:0] INIT = CRC32_INIT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        init,
    input  logic        enable,
    input  logic        bit_in,
    output logic [31:0] crc
);

    logic [31:0] crc_d;
    logic [31:0] crc_q;

    // Next CRC value: preset, advance by one bit, or hold.
    always_comb begin
        crc_d = crc_q;
        if (init) begin
            crc_d = INIT;
        end else if (enable) begin
            crc_d = crc32_step(crc_q, bit_in, POLY);
        end else begin
            crc_d = crc_q;
        end
    end

    // CRC state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            crc_q <= INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/tag_rx_decoder.sv
// DBPSK frame decoder: differential decode of hard phase symbols, MSB-first payload assembly,
// trailing FCS check against the running CRC, premature-end and symbol-timeout aborts.
module tag_rx_decoder
    import tag_rx_decoder_pkg::*;
#(
    parameter int          PAYLOAD_LEN = 8,
    parameter logic [31:0] CRC_POLY    = CRC32_POLY,
    parameter logic [31:0] CRC_INIT    = CRC32_INIT,
    parameter int          SYM_TIMEOUT = 2 * CYCLES_PER_US
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   frame_active,
    input  logic                   sym_valid,
    input  logic                   sym_phase,
    output logic [PAYLOAD_LEN-1:0] payload,
    output logic                   payload_valid,
    output logic                   frame_done,
    output logic                   crc_ok,
    output logic                   frame_abort,
    output logic                   busy
);

    localparam int TMO_W = $clog2(SYM_TIMEOUT + 1);

    state_t                 state_q, state_d;
    logic                   prev_q, prev_d;
    logic [PAYLOAD_LEN-1:0] payload_q, payload_d;
    logic                   payload_valid_q, payload_valid_d;
    logic                   frame_done_q, frame_done_d;
    logic                   crc_ok_q, crc_ok_d;
    logic                   frame_abort_q, frame_abort_d;
    logic                   busy_q, busy_d;
    logic                   mismatch_q, mismatch_d;
    logic [5:0]             bit_cnt_q, bit_cnt_d;
    logic [TMO_W-1:0]       tmo_q, tmo_d;

    logic        dec_bit_s;
    logic        fcs_bit_s;
    logic        bit_err_s;
    logic        tmo_hit_s;
    logic        crc_init_s;
    logic        crc_en_s;
    logic [31:0] crc_s;

    crc32_serial #(
        .POLY (CRC_POLY),
        .INIT (CRC_INIT)
    ) u_crc (
        .clk    (clk),
        .reset  (reset),
        .init   (crc_init_s),
        .enable (crc_en_s),
        .bit_in (dec_bit_s),
        .crc    (crc_s)
    );

    // A phase flip relative to the previous symbol is a 1; the FCS goes out inverted, MSB first.
    assign dec_bit_s = sym_phase ^ prev_q;
    assign fcs_bit_s = ~crc_s[5'd31 - bit_cnt_q[4:0]];
    assign bit_err_s = dec_bit_s ^ fcs_bit_s;
    assign tmo_hit_s = (tmo_q == TMO_W'(SYM_TIMEOUT - 1));

    // Frame FSM, decoder, payload shifter and symbol timeout.
    always_comb begin
        state_d         = state_q;
        prev_d          = prev_q;
        payload_d       = payload_q;
        payload_valid_d = 1'b0;
        frame_done_d    = 1'b0;
        frame_abort_d   = 1'b0;
        crc_ok_d        = crc_ok_q;
        mismatch_d      = mismatch_q;
        bit_cnt_d       = bit_cnt_q;
        tmo_d           = '0;
        crc_init_s      = 1'b0;
        crc_en_s        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (frame_active) begin
                    state_d    = ST_REF;
                    crc_init_s = 1'b1;
                    bit_cnt_d  = 6'd0;
                    crc_ok_d   = 1'b0;
                    mismatch_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REF, ST_PAYLOAD, ST_FCS: begin
                // Losing the envelope wins over a coincident symbol.
                if (!frame_active) begin
                    frame_abort_d = 1'b1;
                    state_d       = ST_IDLE;
                end else if (sym_valid) begin
                    prev_d = sym_phase;
                    case (state_q)
                        ST_REF: begin
                            state_d = ST_PAYLOAD;
                        end
                        ST_PAYLOAD: begin
                            payload_d = (payload_q << 1'b1) | PAYLOAD_LEN'(dec_bit_s);
                            crc_en_s  = 1'b1;
                            if (bit_cnt_q == 6'(PAYLOAD_LEN - 1)) begin
                                payload_valid_d = 1'b1;
                                bit_cnt_d       = 6'd0;
                                state_d         = ST_FCS;
                            end else begin
                                bit_cnt_d = bit_cnt_q + 6'd1;
                            end
                        end
                        ST_FCS: begin
                            mismatch_d = mismatch_q | bit_err_s;
                            if (bit_cnt_q == 6'd31) begin
                                crc_ok_d     = ~(mismatch_q | bit_err_s);
                                frame_done_d = 1'b1;
                                state_d      = ST_HOLD;
                            end else begin
                                bit_cnt_d = bit_cnt_q + 6'd1;
                            end
                        end
                        default: begin
                            state_d = ST_IDLE;
                        end
                    endcase
                end else if (tmo_hit_s) begin
                    // No mid-frame re-sync: park until the envelope ends.
                    frame_abort_d = 1'b1;
                    state_d       = ST_HOLD;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_HOLD: begin
                if (!frame_active) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            prev_q          <= 1'b0;
            payload_q       <= '0;
            payload_valid_q <= 1'b0;
            frame_done_q    <= 1'b0;
            crc_ok_q        <= 1'b0;
            frame_abort_q   <= 1'b0;
            busy_q          <= 1'b0;
            mismatch_q      <= 1'b0;
            bit_cnt_q       <= 6'd0;
            tmo_q           <= '0;
        end else begin
            state_q         <= state_d;
            prev_q          <= prev_d;
            payload_q       <= payload_d;
            payload_valid_q <= payload_valid_d;
            frame_done_q    <= frame_done_d;
            crc_ok_q        <= crc_ok_d;
            frame_abort_q   <= frame_abort_d;
            busy_q          <= busy_d;
            mismatch_q      <= mismatch_d;
            bit_cnt_q       <= bit_cnt_d;
            tmo_q           <= tmo_d;
        end
    end

    assign payload       = payload_q;
    assign payload_valid = payload_valid_q;
    assign frame_done    = frame_done_q;
    assign crc_ok        = crc_ok_q;
    assign frame_abort   = frame_abort_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_tag_rx_decoder.sv
// Directed bench for tag_rx_decoder: DBPSK frames built from a reference CRC-32/BZIP2 model,
// with FCS corruption, envelope loss, symbol timeout, back-to-back frames and reset mid-frame.
module tb_tag_rx_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_active;
    logic       sym_valid;
    logic       sym_phase;
    logic [7:0] payload;
    logic       payload_valid;
    logic       frame_done;
    logic       crc_ok;
    logic       frame_abort;
    logic       busy;

    int errors  = 0;
    int checks  = 0;
    int sym_idx = 0;
    int pv_cnt  = 0;
    int fd_cnt  = 0;
    int ab_cnt  = 0;
    int pv_idx  = 0;
    int fd_idx  = 0;

    always #5 clk = ~clk;

    tag_rx_decoder #(
        .PAYLOAD_LEN (8),
        .CRC_POLY    (32'h04C1_1DB7),
        .CRC_INIT    (32'hFFFF_FFFF),
        .SYM_TIMEOUT (100)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .frame_active  (frame_active),
        .sym_valid     (sym_valid),
        .sym_phase     (sym_phase),
        .payload       (payload),
        .payload_valid (payload_valid),
        .frame_done    (frame_done),
        .crc_ok        (crc_ok),
        .frame_abort   (frame_abort),
        .busy          (busy)
    );

    // Pulse monitor: counts output pulses and records which strobe they followed.
    always @(posedge clk) begin
        #1;
        if (payload_valid) begin
            pv_cnt <= pv_cnt + 1;
            pv_idx <= sym_idx;
        end
        if (frame_done) begin
            fd_cnt <= fd_cnt + 1;
            fd_idx <= sym_idx;
        end
        if (frame_abort) begin
            ab_cnt <= ab_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] golden_fcs(input logic [7:0] pl);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFF_FFFF;
        for (int i = 7; i >= 0; i--) begin
            fb = c[31] ^ pl[i];
            c  = {c[30:0], 1'b0} ^ (fb ? 32'h04C1_1DB7 : 32'h0000_0000);
        end
        return ~c;
    endfunction

    task automatic strobe(input logic ph);
        @(negedge clk);
        sym_valid = 1'b1;
        sym_phase = ph;
        sym_idx++;
        @(negedge clk);
        sym_valid = 1'b0;
    endtask

    // Reference symbol plus up to 40 data bits {payload, fcs}, one strobe every gap clocks.
    task automatic send_frame(input logic [7:0] pl, input logic [31:0] fcs,
                              input int nsym, input int gap);
        logic [39:0] bits;
        logic        ph;
        bits    = {pl, fcs};
        ph      = 1'b0;
        sym_idx = 0;
        strobe(ph);
        for (int i = 1; i < nsym; i++) begin
            repeat (gap - 1) @(negedge clk);
            ph = ph ^ bits[40-i];
            strobe(ph);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int          pv_b, fd_b, ab_b;
        logic [39:0] bits2;
        logic        ph;

        reset        = 1'b1;
        frame_active = 1'b0;
        sym_valid    = 1'b0;
        sym_phase    = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_payload", 32'(payload), 32'h0);
        check("rst_pvalid", 32'(payload_valid), 32'h0);
        check("rst_done", 32'(frame_done), 32'h0);
        check("rst_crc_ok", 32'(crc_ok), 32'h0);
        check("rst_abort", 32'(frame_abort), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);

        // 1: golden frame 0x34
        pv_b = pv_cnt; fd_b = fd_cnt; ab_b = ab_cnt;
        frame_active = 1'b1;
        send_frame(8'h34, golden_fcs(8'h34), 41, 50);
        check("t1_payload", 32'(payload), 32'h34);
        check("t1_pv_count", 32'(pv_cnt - pv_b), 32'd1);
        check("t1_pv_after_strobe", 32'(pv_idx), 32'd9);
        check("t1_done_count", 32'(fd_cnt - fd_b), 32'd1);
        check("t1_done_after_strobe", 32'(fd_idx), 32'd41);
        check("t1_crc_ok", 32'(crc_ok), 32'h1);
        check("t1_no_abort", 32'(ab_cnt - ab_b), 32'd0);
        check("t1_busy_hold", 32'(busy), 32'h1);
        frame_active = 1'b0;
        repeat (2) @(negedge clk);
        check("t1_busy_idle", 32'(busy), 32'h0);
        check("t1_crc_ok_kept", 32'(crc_ok), 32'h1);

        // 2: same frame, last FCS bit flipped
        pv_b = pv_cnt; fd_b = fd_cnt; ab_b = ab_cnt;
        frame_active = 1'b1;
        send_frame(8'h34, golden_fcs(8'h34) ^ 32'h0000_0001, 41, 50);
        check("t2_pv_count", 32'(pv_cnt - pv_b), 32'd1);
        check("t2_done_count", 32'(fd_cnt - fd_b), 32'd1);
        check("t2_crc_bad", 32'(crc_ok), 32'h0);
        check("t2_no_abort", 32'(ab_cnt - ab_b), 32'd0);
        frame_active = 1'b0;
        repeat (2) @(negedge clk);

        // 3: envelope drops after 20 symbols
        fd_b = fd_cnt;
        frame_active = 1'b1;
        send_frame(8'h5A, golden_fcs(8'h5A), 20, 50);
        @(negedge clk);
        frame_active = 1'b0;
        @(negedge clk);
        check("t3_abort_pulse", 32'(frame_abort), 32'h1);
        check("t3_busy", 32'(busy), 32'h0);
        check("t3_crc_ok", 32'(crc_ok), 32'h0);
        check("t3_no_done", 32'(fd_cnt - fd_b), 32'd0);
        @(negedge clk);
        check("t3_abort_one_cycle", 32'(frame_abort), 32'h0);

        // 4: symbol gap of 120 clocks after symbol 5
        pv_b = pv_cnt; ab_b = ab_cnt;
        frame_active = 1'b1;
        send_frame(8'hC3, golden_fcs(8'hC3), 5, 50);
        repeat (99) @(negedge clk);
        check("t4_no_early_abort", 32'(ab_cnt - ab_b), 32'd0);
        @(negedge clk);
        check("t4_abort_at_100", 32'(frame_abort), 32'h1);
        check("t4_busy_hold", 32'(busy), 32'h1);
        repeat (20) @(negedge clk);
        strobe(1'b1);
        @(negedge clk);
        check("t4_hold_busy", 32'(busy), 32'h1);
        check("t4_abort_count", 32'(ab_cnt - ab_b), 32'd1);
        check("t4_no_pv", 32'(pv_cnt - pv_b), 32'd0);
        frame_active = 1'b0;
        repeat (2) @(negedge clk);
        check("t4_idle", 32'(busy), 32'h0);
        frame_active = 1'b1;
        send_frame(8'hA5, golden_fcs(8'hA5), 41, 50);
        check("t4_a5_payload", 32'(payload), 32'hA5);
        check("t4_a5_crc_ok", 32'(crc_ok), 32'h1);

        // 5: back-to-back 0xFF then 0x00 with one idle clock
        frame_active = 1'b0;
        repeat (2) @(negedge clk);
        frame_active = 1'b1;
        send_frame(8'hFF, golden_fcs(8'hFF), 41, 4);
        check("t5_ff_payload", 32'(payload), 32'hFF);
        check("t5_ff_crc_ok", 32'(crc_ok), 32'h1);
        @(negedge clk);
        frame_active = 1'b0;
        @(negedge clk);
        frame_active = 1'b1;
        bits2   = {8'h00, golden_fcs(8'h00)};
        ph      = 1'b0;
        sym_idx = 0;
        strobe(ph);
        check("t5_ff_held_after_ref", 32'(payload), 32'hFF);
        check("t5_crc_ok_cleared", 32'(crc_ok), 32'h0);
        ph = ph ^ bits2[39];
        strobe(ph);
        check("t5_first_bit_shift", 32'(payload), 32'hFE);
        for (int i = 2; i < 41; i++) begin
            repeat (3) @(negedge clk);
            ph = ph ^ bits2[40-i];
            strobe(ph);
        end
        check("t5_00_payload", 32'(payload), 32'h00);
        check("t5_00_crc_ok", 32'(crc_ok), 32'h1);
        frame_active = 1'b0;
        repeat (2) @(negedge clk);

        // 6: reset asserted mid-FCS, strobes during reset ignored
        frame_active = 1'b1;
        send_frame(8'h34, golden_fcs(8'h34), 20, 4);
        check("t6_payload_pre", 32'(payload), 32'h34);
        reset = 1'b1;
        @(negedge clk);
        check("t6_rst_payload", 32'(payload), 32'h0);
        check("t6_rst_busy", 32'(busy), 32'h0);
        check("t6_rst_crc_ok", 32'(crc_ok), 32'h0);
        check("t6_rst_pulses", 32'({payload_valid, frame_done, frame_abort}), 32'h0);
        pv_b = pv_cnt; fd_b = fd_cnt; ab_b = ab_cnt;
        for (int i = 0; i < 10; i++) begin
            strobe(1'(i));
        end
        check("t6_strobes_ignored", 32'(payload), 32'h0);
        check("t6_busy_in_reset", 32'(busy), 32'h0);
        frame_active = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("t6_post_busy", 32'(busy), 32'h0);
        check("t6_post_payload", 32'(payload), 32'h0);
        check("t6_no_pulses", 32'((pv_cnt - pv_b) + (fd_cnt - fd_b) + (ab_cnt - ab_b)), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
